fpmult_exception_module: RTL and testbench

Final stage of the single-precision floating-point multiplier pipeline. It takes the rounded mantissa, the widened biased exponent and the result sign, detects exponent overflow and underflow, and packs a registered IEEE-754 binary32 word. It sits directly after the rounding stage and drives the multiplier's product output.

---
 rtl/fpmult_exception_module_pkg.sv | 26 ++
 rtl/fpmult_exception_module_if.sv | 17 +
 rtl/fpmult_exception_module.sv | 41 ++++
 tb/tb_fpmult_exception_module.sv | 110 +++++++++++
 4 files changed

// File: rtl/fpmult_exception_module_pkg.sv
// Shared binary32 definitions for the floating-point multiplier stages.
package fpmult_exception_module_pkg;

    localparam int FP_MANT_W = 23;
    localparam int FP_EXP_W  = 8;
    localparam int FP_WORD_W = 32;

    localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;

    // Result category chosen by the exception stage.
    typedef enum logic [1:0] {
        CLS_NORMAL   = 2'd0,
        CLS_OVERFLOW = 2'd1,
        CLS_ZERO     = 2'd2
    } fpClass_t;

    // Assemble {sign, biased exponent, fraction} into one binary32 word.
    function automatic logic [FP_WORD_W-1:0] packFp(
        input logic                sgn,
        input logic [FP_EXP_W-1:0] exp,
        input logic [FP_MANT_W-1:0] mant
    );
        return {sgn, exp, mant};
    endfunction

endpackage

// File: rtl/fpmult_exception_module_if.sv
// Operand/result bundle between the rounding stage and the exception stage.
// No handshake: the rounding stage presents a new operand set every cycle and
// the exception stage samples it on every rising edge unconditionally.
interface fpmult_exception_module_if;
    import fpmult_exception_module_pkg::*;

    logic [FP_MANT_W-1:0] RoundM;
    logic [FP_EXP_W:0]    RoundE;
    logic                 Sgn;
    logic [FP_WORD_W-1:0] P;

    // Upstream side: drives the rounded operand, observes the packed product.
    modport master (output RoundM, output RoundE, output Sgn, input P);
    // Exception stage side.
    modport slave  (input RoundM, input RoundE, input Sgn, output P);

endinterface

// File: rtl/fpmult_exception_module.sv
// Exception stage: classifies the rounded exponent as overflow, zero or
// normal and registers the packed binary32 product.
module fpmult_exception_module
    import fpmult_exception_module_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    fpmult_exception_module_if.slave   bus
);

    fpClass_t             resClass;
    logic [FP_WORD_W-1:0] pNext;
    logic [FP_WORD_W-1:0] pReg;

    // Classify the current exponent and build the next product word.
    always_comb begin
        resClass = CLS_NORMAL;
        pNext    = packFp(bus.Sgn, bus.RoundE[FP_EXP_W-1:0], bus.RoundM);
        // Overflow wins over zero; the carry bit alone already means E >= 256.
        if (bus.RoundE[FP_EXP_W] || (bus.RoundE[FP_EXP_W-1:0] == FP_EXP_MAX)) begin
            resClass = CLS_OVERFLOW;
            pNext    = packFp(bus.Sgn, FP_EXP_MAX, '0);
        end else if (bus.RoundE == '0) begin
            // Denormals are flushed: the mantissa is dropped, sign kept.
            resClass = CLS_ZERO;
            pNext    = packFp(bus.Sgn, '0, '0);
        end
    end

    // Output register, cleared immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pReg <= '0;
        end else begin
            pReg <= pNext;
        end
    end

    assign bus.P = pReg;

endmodule

// File: tb/tb_fpmult_exception_module.sv
// Directed bench for the multiplier exception/pack stage.
module tb_fpmult_exception_module;

    typedef struct packed {
        logic        sgn;
        logic [8:0]  e;
        logic [22:0] m;
        logic [31:0] p;
    } vec_t;

    localparam int N_VEC = 14;

    logic clk;
    logic rst_n;
    int   nVec;
    int   nErr;
    vec_t vecs[N_VEC];
    logic [31:0] prevExp;

    fpmult_exception_module_if bus();

    fpmult_exception_module dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare P against a bench-computed value
    task automatic checkP(input string name, input logic [31:0] expP);
        nVec++;
        if (bus.P !== expP) begin
            nErr++;
            $display("FAIL %s: P=%h expected %h", name, bus.P, expP);
        end
    endtask

    task automatic drive(input logic sgn, input logic [8:0] e, input logic [22:0] m);
        bus.Sgn    = sgn;
        bus.RoundE = e;
        bus.RoundM = m;
    endtask

    initial begin
        nVec = 0;
        nErr = 0;

        vecs[0]  = {1'b0, 9'h07F, 23'h600000, 32'h3FE00000};
        vecs[1]  = {1'b1, 9'h07F, 23'h603300, 32'hBFE03300};
        vecs[2]  = {1'b0, 9'h083, 23'h002000, 32'h41802000};
        vecs[3]  = {1'b0, 9'h021, 23'h700F03, 32'h10F00F03};
        vecs[4]  = {1'b0, 9'h0FF, 23'h123456, 32'h7F800000};
        vecs[5]  = {1'b1, 9'h100, 23'h2AAAAA, 32'hFF800000};
        vecs[6]  = {1'b0, 9'h1FF, 23'h7FFFFF, 32'h7F800000};
        vecs[7]  = {1'b0, 9'h17F, 23'h000001, 32'h7F800000};
        vecs[8]  = {1'b0, 9'h000, 23'h7FFFFF, 32'h00000000};
        vecs[9]  = {1'b1, 9'h000, 23'h5A5A5A, 32'h80000000};
        vecs[10] = {1'b0, 9'h0FE, 23'h7FFFFF, 32'h7F7FFFFF};
        vecs[11] = {1'b0, 9'h001, 23'h000000, 32'h00800000};
        vecs[12] = {1'b1, 9'h0FE, 23'h000000, 32'hFF000000};
        vecs[13] = {1'b1, 9'h001, 23'h012345, 32'h80812345};

        // Asynchronous reset with arbitrary inputs, between clock edges
        rst_n = 1'b1;
        drive(1'b1, 9'h0AB, 23'h3C3C3C);
        #2 rst_n = 1'b0;
        #1 checkP("reset_async", 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 checkP("reset_hold", 32'h0);

        // Release, first valid result after one edge
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 9'h080, 23'h400000);
        @(posedge clk);
        #1 checkP("after_reset_3p0", 32'h40400000);
        prevExp = 32'h40400000;

        // Back-to-back table: new inputs every cycle, mid-cycle input
        // changes must not disturb the registered output
        for (int i = 0; i < N_VEC; i++) begin
            drive(vecs[i].sgn, vecs[i].e, vecs[i].m);
            #2 checkP($sformatf("hold_midcycle_%0d", i), prevExp);
            @(posedge clk);
            #1 checkP($sformatf("vec_%0d", i), vecs[i].p);
            prevExp = vecs[i].p;
        end

        // Reset pulse mid-stream while P is nonzero
        drive(1'b0, 9'h083, 23'h002000);
        #2 rst_n = 1'b0;
        #1 checkP("reset_midstream", 32'h0);
        #1 rst_n = 1'b1;
        #1 checkP("reset_released_no_edge", 32'h0);
        @(posedge clk);
        #1 checkP("resume_after_reset", 32'h41802000);

        drive(1'b1, 9'h000, 23'h7FFFFF);
        @(posedge clk);
        #1 checkP("resume_zero", 32'h80000000);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
